// File: rtl/fb_writer.sv
// Framebuffer write side: PPU shade stream -> palette RGB -> {y,x} address,
// buffered in a small first-word-fall-through FIFO ahead of a stallable port.
module fb_writer #(
  parameter int         H_PIXELS   = 160,
  parameter int         V_LINES    = 144,
  parameter logic [7:0] X_ORIGIN   = 8'd0,
  parameter logic [7:0] Y_ORIGIN   = 8'd0,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        resetN,
  input  logic        pixValid,
  output logic        pixReady,
  input  logic [1:0]  pixShade,
  input  logic        pixFirst,
  input  logic [7:0]  palette,
  output logic        fbWe,
  input  logic        fbReady,
  output logic [15:0] fbAddr,
  output logic [23:0] fbData,
  output logic [15:0] ppu_addr,
  output logic        frameDone,
  output logic        syncErr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 41;

  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    x_q, y_q;
  logic [15:0]   ppu_q;
  logic [23:0]   dat_q;
  logic          done_q, serr_q;

  logic          accept, commit;
  logic [7:0]    px, py, nx, ny;
  logic          last_pix;
  logic [1:0]    idx;
  logic [23:0]   rgb;
  logic [EW-1:0] entry, head;

  assign pixReady = resetN && (cnt_q < CW'(FIFO_DEPTH));
  assign accept   = pixValid && pixReady;
  assign fbWe     = (cnt_q != '0);
  assign commit   = fbWe && fbReady;

  assign px       = pixFirst ? 8'd0 : x_q;
  assign py       = pixFirst ? 8'd0 : y_q;
  assign last_pix = (px == 8'(H_PIXELS - 1)) && (py == 8'(V_LINES - 1));

  always_comb begin
    nx = px + 8'd1;
    ny = py;
    if (px == 8'(H_PIXELS - 1)) begin
      nx = 8'd0;
      ny = (py == 8'(V_LINES - 1)) ? 8'd0 : py + 8'd1;
    end
  end

  assign idx = palette[{pixShade, 1'b0} +: 2];

  always_comb begin
    rgb = 24'hD0F8E0;
    unique case (idx)
      2'd0: rgb = 24'hD0F8E0;
      2'd1: rgb = 24'h70C088;
      2'd2: rgb = 24'h566834;
      2'd3: rgb = 24'h201808;
    endcase
  end

  assign entry = {last_pix, Y_ORIGIN + py, X_ORIGIN + px, rgb};
  assign head  = mem_q[rd_q];

  // When empty, replay the last committed word so the port stays stable.
  assign fbAddr    = fbWe ? head[39:24] : ppu_q;
  assign fbData    = fbWe ? head[23:0]  : dat_q;
  assign ppu_addr  = ppu_q;
  assign frameDone = done_q;
  assign syncErr   = serr_q;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({accept, commit})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (accept) mem_q[wr_q] <= entry;
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      x_q    <= 8'd0;
      y_q    <= 8'd0;
      ppu_q  <= 16'd0;
      dat_q  <= 24'd0;
      done_q <= 1'b0;
      serr_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= commit && head[EW-1];
      if (accept) begin
        wr_q <= wr_q + AW'(1);
        x_q  <= nx;
        y_q  <= ny;
        if (pixFirst && (x_q != 8'd0 || y_q != 8'd0)) serr_q <= 1'b1;
      end
      if (commit) begin
        rd_q  <= rd_q + AW'(1);
        ppu_q <= head[39:24];
        dat_q <= head[23:0];
      end
    end
  end

endmodule

// File: tb/tb_fb_writer.sv
// Directed bench for fb_writer: palette table, full frame, backpressure,
// resync, origin wrap and mid-stream reset.
module tb_fb_writer;

  logic        clock = 1'b0;
  logic        resetN;
  logic        pixValid, pixFirst, fbReady;
  logic [1:0]  pixShade;
  logic [7:0]  palette;
  logic        pixReady, fbWe, frameDone, syncErr;
  logic [15:0] fbAddr, ppu_addr;
  logic [23:0] fbData;
  logic        o_pixReady, o_fbWe, o_frameDone, o_syncErr;
  logic [15:0] o_fbAddr, o_ppu_addr;
  logic [23:0] o_fbData;

  always #5 clock = ~clock;

  fb_writer dut (
    .clock(clock), .resetN(resetN), .pixValid(pixValid),
    .pixReady(pixReady), .pixShade(pixShade), .pixFirst(pixFirst),
    .palette(palette), .fbWe(fbWe), .fbReady(fbReady),
    .fbAddr(fbAddr), .fbData(fbData), .ppu_addr(ppu_addr),
    .frameDone(frameDone), .syncErr(syncErr)
  );

  fb_writer #(.X_ORIGIN(8'd200), .Y_ORIGIN(8'd250)) u_org (
    .clock(clock), .resetN(resetN), .pixValid(pixValid),
    .pixReady(o_pixReady), .pixShade(pixShade), .pixFirst(pixFirst),
    .palette(palette), .fbWe(o_fbWe), .fbReady(fbReady),
    .fbAddr(o_fbAddr), .fbData(o_fbData), .ppu_addr(o_ppu_addr),
    .frameDone(o_frameDone), .syncErr(o_syncErr)
  );

  int total = 0;
  int passed = 0;

  task automatic chk(input string nm, input logic [47:0] got,
                     input logic [47:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h want %h", nm, got, exp);
  endtask

  // Commit monitor: row-major address model plus ppu_addr tracking.
  int          mon_cnt = 0, mon_err = 0, fd_cnt = 0, fd_at = 0;
  int          base = 0;
  bit          mon_en = 0;
  logic [23:0] exp_data = 24'h0;
  bit          prev_c = 0;
  logic [15:0] prev_a = 16'h0;

  always @(negedge clock) begin
    int k;
    if (!resetN) prev_c = 0;
    if (prev_c && ppu_addr !== prev_a) mon_err++;
    if (frameDone) begin
      fd_cnt++;
      fd_at = mon_cnt;
    end
    prev_c = fbWe && fbReady;
    prev_a = fbAddr;
    if (fbWe && fbReady) begin
      k = mon_cnt - base;
      if (mon_en && (fbAddr !== {8'(k / 160), 8'(k % 160)} ||
                     fbData !== exp_data)) mon_err++;
      mon_cnt++;
    end
  end

  task automatic send(input logic [1:0] sh, input logic first);
    int n = 0;
    pixShade = sh;
    pixFirst = first;
    pixValid = 1'b1;
    while (!pixReady && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    if (n >= 50) begin
      total++;
      $display("FAIL send_timeout: got pixReady=0 want 1");
    end
    @(posedge clock); #1;
    pixValid = 1'b0;
    pixFirst = 1'b0;
  endtask

  task automatic do_reset();
    resetN   = 1'b0;
    pixValid = 1'b0;
    pixFirst = 1'b0;
    repeat (2) @(posedge clock);
    #3 resetN = 1'b1;
    @(posedge clock); #1;
  endtask

  typedef struct {
    logic [7:0]  pal;
    logic [1:0]  sh;
    logic        first;
    logic [23:0] data;
    logic [15:0] addr;
    logic [15:0] ppu;
  } vec_t;

  vec_t tbl [8];
  int   e0, idx;

  initial begin
    tbl[0] = '{8'h1B, 2'd0, 1'b1, 24'h201808, 16'h0000, 16'h0000};
    tbl[1] = '{8'h1B, 2'd1, 1'b0, 24'h566834, 16'h0001, 16'h0000};
    tbl[2] = '{8'h1B, 2'd2, 1'b0, 24'h70C088, 16'h0002, 16'h0001};
    tbl[3] = '{8'h1B, 2'd3, 1'b0, 24'hD0F8E0, 16'h0003, 16'h0002};
    tbl[4] = '{8'hE4, 2'd0, 1'b0, 24'hD0F8E0, 16'h0004, 16'h0003};
    tbl[5] = '{8'hE4, 2'd3, 1'b0, 24'h201808, 16'h0005, 16'h0004};
    tbl[6] = '{8'h4E, 2'd1, 1'b0, 24'h201808, 16'h0006, 16'h0005};
    tbl[7] = '{8'h4E, 2'd2, 1'b0, 24'hD0F8E0, 16'h0007, 16'h0006};

    resetN   = 1'b0;
    pixValid = 1'b0;
    pixFirst = 1'b0;
    pixShade = 2'd0;
    palette  = 8'hE4;
    fbReady  = 1'b1;
    repeat (2) @(posedge clock);
    #2;
    chk("rst_pixReady", 48'(pixReady), 48'h0);
    chk("rst_fbWe", 48'(fbWe), 48'h0);
    chk("rst_fbAddr", 48'(fbAddr), 48'h0);
    chk("rst_fbData", 48'(fbData), 48'h0);
    chk("rst_ppu", 48'(ppu_addr), 48'h0);
    chk("rst_frameDone", 48'(frameDone), 48'h0);
    chk("rst_syncErr", 48'(syncErr), 48'h0);
    #3 resetN = 1'b1;
    @(posedge clock); #1;

    for (int i = 0; i < 8; i++) begin
      palette = tbl[i].pal;
      send(tbl[i].sh, tbl[i].first);
      #3;
      chk($sformatf("pal%0d_we", i), 48'(fbWe), 48'h1);
      chk($sformatf("pal%0d_data", i), 48'(fbData), 48'(tbl[i].data));
      chk($sformatf("pal%0d_addr", i), 48'(fbAddr), 48'(tbl[i].addr));
      chk($sformatf("pal%0d_ppu", i), 48'(ppu_addr), 48'(tbl[i].ppu));
      if (i == 0) chk("org_first", 48'(o_fbAddr), 48'hFAC8);
    end
    repeat (3) @(posedge clock);
    #3;
    chk("empty_we", 48'(fbWe), 48'h0);
    chk("empty_addr_hold", 48'(fbAddr), 48'h0007);
    chk("empty_data_hold", 48'(fbData), 48'hD0F8E0);

    // full frame, continuous flow
    do_reset();
    palette  = 8'hE4;
    exp_data = 24'hD0F8E0;
    base     = mon_cnt;
    e0       = mon_err;
    mon_en   = 1;
    idx      = fd_cnt;
    for (int i = 0; i < 23040; i++) begin
      send(2'd0, i == 0);
      if (i == 60) begin
        #3;
        chk("org_60_0", 48'(o_fbAddr), 48'hFA04);
        chk("dut_60_0", 48'(fbAddr), 48'h003C);
      end
      if (i == 960) begin
        #3;
        chk("org_0_6", 48'(o_fbAddr), 48'h00C8);
        chk("dut_0_6", 48'(fbAddr), 48'h0600);
      end
    end
    repeat (4) @(posedge clock);
    #3;
    chk("frame_commits", 48'(mon_cnt - base), 48'd23040);
    chk("frame_order", 48'(mon_err - e0), 48'd0);
    chk("frame_done_cnt", 48'(fd_cnt - idx), 48'd1);
    chk("frame_done_at", 48'(fd_at - base), 48'd23040);
    chk("frame_last_ppu", 48'(ppu_addr), 48'h8F9F);
    chk("frame_syncErr", 48'(syncErr), 48'h0);

    // backpressure: 6 offered against a stalled port
    do_reset();
    base     = mon_cnt;
    e0       = mon_err;
    fbReady  = 1'b0;
    idx      = 0;
    pixShade = 2'd0;
    pixFirst = 1'b1;
    pixValid = 1'b1;
    for (int c = 0; c < 26; c++) begin
      bit acc;
      if (c == 6) begin
        #3;
        chk("bp_accepts", 48'(idx), 48'd4);
        chk("bp_pixReady", 48'(pixReady), 48'h0);
        chk("bp_fbWe", 48'(fbWe), 48'h1);
        chk("bp_head", 48'(fbAddr), 48'h0000);
        chk("bp_ppu", 48'(ppu_addr), 48'h0000);
        fbReady = 1'b1;
      end
      acc = pixValid && pixReady;
      @(posedge clock); #1;
      if (acc) idx++;
      pixFirst = 1'b0;
      pixValid = (idx < 6);
    end
    chk("bp_all_accepted", 48'(idx), 48'd6);
    chk("bp_commits", 48'(mon_cnt - base), 48'd6);
    chk("bp_order_ppu", 48'(mon_err - e0), 48'd0);
    chk("bp_final_ppu", 48'(ppu_addr), 48'h0005);
    chk("bp_drained", 48'(fbWe), 48'h0);

    // resync at pixel 37 of line 5
    do_reset();
    mon_en = 0;
    for (int i = 0; i < 837; i++) send(2'd0, i == 0);
    #3;
    chk("rs_pre_syncErr", 48'(syncErr), 48'h0);
    send(2'd0, 1'b1);
    #3;
    chk("rs_addr", 48'(fbAddr), 48'h0000);
    chk("rs_syncErr", 48'(syncErr), 48'h1);
    chk("rs_org_addr", 48'(o_fbAddr), 48'hFAC8);
    send(2'd0, 1'b0);
    #3;
    chk("rs_next_addr", 48'(fbAddr), 48'h0001);
    repeat (10) @(posedge clock);
    #3;
    chk("rs_sticky", 48'(syncErr), 48'h1);

    // reset mid-stream with three queued entries
    @(posedge clock); #1;
    fbReady = 1'b1;
    send(2'd0, 1'b1);
    send(2'd0, 1'b0);
    @(posedge clock); #1;
    fbReady = 1'b0;
    send(2'd0, 1'b0);
    send(2'd0, 1'b0);
    send(2'd0, 1'b0);
    #3;
    chk("mr_pre_ppu", 48'(ppu_addr), 48'h0001);
    chk("mr_pre_we", 48'(fbWe), 48'h1);
    chk("mr_pre_head", 48'(fbAddr), 48'h0002);
    chk("mr_pre_syncErr", 48'(syncErr), 48'h1);
    #3 resetN = 1'b0;
    #1;
    chk("mr_we", 48'(fbWe), 48'h0);
    chk("mr_ppu", 48'(ppu_addr), 48'h0);
    chk("mr_pixReady", 48'(pixReady), 48'h0);
    base = mon_cnt;
    repeat (2) @(posedge clock);
    #3 resetN = 1'b1;
    fbReady = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    chk("mr_no_writes", 48'(mon_cnt - base), 48'd0);
    send(2'd0, 1'b1);
    #3;
    chk("mr_first_addr", 48'(fbAddr), 48'h0000);
    chk("mr_first_we", 48'(fbWe), 48'h1);
    chk("mr_syncErr", 48'(syncErr), 48'h0);
    repeat (3) @(posedge clock);
    #3;
    chk("mr_one_write", 48'(mon_cnt - base), 48'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
